// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the shift sequencer block:
//   - state_t    : FSM state encoding (IDLE, SHIFT, DONE)
//   - DIR_LEFT   : shift toward the MSB, MSB leaves first
//   - DIR_RIGHT  : shift toward the LSB, LSB leaves first
//   - clamp_count: saturates a requested shift count at the register width
// Optional feature macro used by this block: SHIFT_SEQUENCER_ROTATE_EN
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Saturate a requested count at the register width so the counter never
  // has to represent more shifts than there are bits.
  function automatic int unsigned clamp_count(input int unsigned count,
                                              input int unsigned limit);
    int unsigned result;
    if (count > limit) begin
      result = limit;
    end else begin
      result = count;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_sequencer_datapath.sv
// -----------------------------------------------------------------------------
// shift_sequencer_datapath
// WIDTH-bit bidirectional shift register with load / shift / hold control and
// fill-bit selection (serial input or recirculated outgoing bit).
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous active-high reset (register cleared)
//   i_load         load i_parallel_in (has priority over i_shift)
//   i_shift        shift one position in direction i_direction
//   i_direction    DIR_LEFT (MSB out) or DIR_RIGHT (LSB out), already latched
//   i_rotate       1: fill with the bit leaving the register
//   i_serial_in    fill bit when not rotating
//   i_parallel_in  word to load
//   o_serial_out   bit that leaves at the next shift
//   o_parallel_out register contents
// -----------------------------------------------------------------------------
module shift_sequencer_datapath
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_direction,
  input  logic             i_rotate,
  input  logic             i_serial_in,
  input  logic [WIDTH-1:0] i_parallel_in,
  output logic             o_serial_out,
  output logic [WIDTH-1:0] o_parallel_out
);

  logic [WIDTH-1:0] r_word;
  logic             w_out_bit;
  logic             w_fill;

  // The outgoing bit is the end the register is moving away from.
  assign w_out_bit = (i_direction == DIR_RIGHT) ? r_word[0] : r_word[WIDTH-1];
  assign w_fill    = i_rotate ? w_out_bit : i_serial_in;

  // Shift register: load, shift or hold.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_word <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_word <= i_parallel_in;
    end else if (i_shift) begin
      if (i_direction == DIR_LEFT) begin
        r_word <= {r_word[WIDTH-2:0], w_fill};
      end else begin
        r_word <= {w_fill, r_word[WIDTH-1:1]};
      end
    end else begin
      r_word <= r_word;
    end
  end

  assign o_serial_out   = w_out_bit;
  assign o_parallel_out = r_word;

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Sequencer for a WIDTH-bit bidirectional shift register: parallel-loads a
// word on i_start, shifts it min(i_shift_count, WIDTH) positions while
// streaming bits out on o_serial_out, then pulses o_done for one cycle.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN adds i_rotate (latched at
// start); when set, the fill bit is the bit shifted out and i_serial_in is
// ignored.
// Ports:
//   i_clock         rising-edge clock
//   i_reset         asynchronous active-high reset
//   i_start         request, sampled only in IDLE
//   i_direction     0 = left (MSB first), 1 = right (LSB first), latched
//   i_shift_count   number of shifts (clamped to WIDTH), latched
//   i_parallel_in   word loaded at start
//   i_serial_in     fill bit for each shift
//   i_rotate        (macro only) recirculate outgoing bit, latched
//   o_serial_out    bit leaving at the next shift
//   o_parallel_out  register contents
//   o_busy          high in SHIFT and DONE
//   o_done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_direction,
  input  logic [CW-1:0]    i_shift_count,
  input  logic [WIDTH-1:0] i_parallel_in,
  input  logic             i_serial_in,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             i_rotate,
`endif
  output logic             o_serial_out,
  output logic [WIDTH-1:0] o_parallel_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_direction;
  logic            r_busy;
  logic            r_done;
  logic            w_rotate;
  logic            w_load;
  logic            w_shift;
  logic [CW-1:0]   w_count_clamped;

  assign w_count_clamped = CW'(clamp_count(32'(i_shift_count), 32'(WIDTH)));
  assign w_load          = (r_state == IDLE) && i_start;
  assign w_shift         = (r_state == SHIFT);

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic r_rotate;

  // Rotate mode is captured with the rest of the request.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rotate <= 1'b0;
    end else if (w_load) begin
      r_rotate <= i_rotate;
    end else begin
      r_rotate <= r_rotate;
    end
  end

  assign w_rotate = r_rotate;
`else
  assign w_rotate = 1'b0;
`endif

  // Control FSM: state, shift counter, latched direction and registered
  // busy/done flags (set together with the state they describe).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_count     <= COUNT_ZERO;
      r_direction <= DIR_LEFT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_direction <= i_direction;
            r_count     <= w_count_clamped;
            r_busy      <= 1'b1;
            if (w_count_clamped == COUNT_ZERO) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= SHIFT;
              r_done  <= 1'b0;
            end
          end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
          end
        end
        SHIFT: begin
          r_busy <= 1'b1;
          // Finishing on <= 1 keeps the counter from ever wrapping.
          if (r_count <= COUNT_ONE) begin
            r_count <= COUNT_ZERO;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - COUNT_ONE;
            r_done  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_count <= COUNT_ZERO;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  shift_sequencer_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_load         (w_load),
    .i_shift        (w_shift),
    .i_direction    (r_direction),
    .i_rotate       (w_rotate),
    .i_serial_in    (i_serial_in),
    .i_parallel_in  (i_parallel_in),
    .o_serial_out   (o_serial_out),
    .o_parallel_out (o_parallel_out)
  );

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       direction;
  logic [3:0] shift_count;
  logic [7:0] parallel_in;
  logic       serial_in;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic       rotate;
`endif
  logic       serial_out;
  logic [7:0] parallel_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic q_exp[$];

  shift_sequencer #(.WIDTH(8), .CW(4)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_direction    (direction),
    .i_shift_count  (shift_count),
    .i_parallel_in  (parallel_in),
    .i_serial_in    (serial_in),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .i_rotate       (rotate),
`endif
    .o_serial_out   (serial_out),
    .o_parallel_out (parallel_out),
    .o_busy         (busy),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: predicted stream goes to the scoreboard at start,
  // and is popped during each SHIFT cycle.
  task automatic do_op(input string tag, input logic [7:0] pin, input logic d,
                       input logic [3:0] cnt, input logic sin, input logic rot,
                       input logic [7:0] exp_final);
    int n;
    logic [7:0] w;
    logic ob;
    logic fill;
    logic e;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    w = pin;
    for (int k = 0; k < n; k++) begin
      ob = d ? w[0] : w[7];
      q_exp.push_back(ob);
      fill = rot ? ob : sin;
      w = d ? {fill, w[7:1]} : {w[6:0], fill};
    end
    start       = 1'b1;
    parallel_in = pin;
    direction   = d;
    shift_count = cnt;
    serial_in   = sin;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    rotate      = rot;
`endif
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, "_busy_shift"}, busy, 1);
      check({tag, "_done_shift"}, done, 0);
      e = q_exp.pop_front();
      check({tag, "_serial_out"}, serial_out, e);
      tick();
    end
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_final"}, parallel_out, exp_final);
    tick();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_hold"}, parallel_out, exp_final);
    check({tag, "_sb_empty"}, q_exp.size(), 0);
  endtask

  initial begin
    int n_done;
    int n_busy;
    reset       = 1'b1;
    start       = 1'b0;
    direction   = 1'b0;
    shift_count = 4'd0;
    parallel_in = 8'h00;
    serial_in   = 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    rotate      = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", serial_out, 0);
    check("rst_pout", parallel_out, 0);
    reset = 1'b0;
    tick();

    // Right shift with fill 1
    do_op("t3", 8'h81, 1'b1, 4'd3, 1'b1, 1'b0, 8'hF0);

    // Leave the register holding 8'h81, right direction, so SerialOut is 1
    do_op("pre_idle", 8'h81, 1'b1, 4'd0, 1'b0, 1'b0, 8'h81);
    check("pre_idle_sout", serial_out, 1);

    // Reset while idle: outputs clear before any clock edge
    #3;
    reset = 1'b1;
    #1;
    check("idle_rst_sout", serial_out, 0);
    check("idle_rst_pout", parallel_out, 0);
    check("idle_rst_busy", busy, 0);
    check("idle_rst_done", done, 0);
    #2;
    reset = 1'b0;
    tick();

    // Reset three cycles into a SHIFT
    start       = 1'b1;
    parallel_in = 8'hA5;
    direction   = 1'b0;
    shift_count = 4'd8;
    serial_in   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sout", serial_out, 0);
    check("mid_rst_pout", parallel_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    #3;
    reset = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_no_busy", n_busy, 0);

    // Full left shift after the aborted run
    do_op("t2", 8'hA5, 1'b0, 4'd8, 1'b0, 1'b0, 8'h00);

    // Count boundaries
    do_op("t4_zero", 8'h3C, 1'b0, 4'd0, 1'b1, 1'b0, 8'h3C);
    do_op("t4_clamp", 8'hC3, 1'b1, 4'd12, 1'b1, 1'b0, 8'hFF);
    do_op("t4_left_clamp", 8'h96, 1'b0, 4'd15, 1'b0, 1'b0, 8'h00);

    // Start held high: no reload before EN+2, ParallelIn ignored in SHIFT
    start       = 1'b1;
    parallel_in = 8'hFF;
    direction   = 1'b0;
    shift_count = 4'd2;
    serial_in   = 1'b0;
    tick();
    check("t5_c0_busy", busy, 1);
    check("t5_c0_pout", parallel_out, 8'hFF);
    check("t5_c0_sout", serial_out, 1);
    parallel_in = 8'h00;
    tick();
    check("t5_c1_pout", parallel_out, 8'hFE);
    check("t5_c1_sout", serial_out, 1);
    check("t5_c1_done", done, 0);
    tick();
    check("t5_done", done, 1);
    check("t5_done_pout", parallel_out, 8'hFC);
    parallel_in = 8'h5A;
    tick();
    check("t5_idle_busy", busy, 0);
    check("t5_idle_pout", parallel_out, 8'hFC);
    tick();
    check("t5_reload_busy", busy, 1);
    check("t5_reload_pout", parallel_out, 8'h5A);
    start = 1'b0;
    tick();
    tick();
    check("t5_2nd_done", done, 1);
    tick();
    check("t5_2nd_idle", busy, 0);
    check("t5_2nd_pout", parallel_out, 8'h68);

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    do_op("t6_rot1", 8'h81, 1'b0, 4'd1, 1'b0, 1'b1, 8'h03);
    do_op("t6_rot8_s0", 8'h81, 1'b0, 4'd8, 1'b0, 1'b1, 8'h81);
    do_op("t6_rot8_s1", 8'h81, 1'b0, 4'd8, 1'b1, 1'b1, 8'h81);
    do_op("t6_rotr3", 8'h81, 1'b1, 4'd3, 1'b0, 1'b1, 8'h30);
    do_op("t6_norot", 8'h81, 1'b0, 4'd1, 1'b0, 1'b0, 8'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
